// File: rtl/mips_pkg.sv
// Shared MIPS multicycle definitions: opcodes, controller states and
// datapath select encodings used by the sequencing controller.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BEQ    = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_t;

  typedef enum logic [1:0] {
    SRCB_RT     = 2'b00,
    SRCB_FOUR   = 2'b01,
    SRCB_IMM    = 2'b10,
    SRCB_IMM_SH = 2'b11
  } alu_src_b_t;

  typedef enum logic [1:0] {
    PC_ALU    = 2'b00,
    PC_ALUOUT = 2'b01,
    PC_JUMP   = 2'b10
  } pc_src_t;

  typedef struct packed {
    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    alu_src_b_t alu_src_b;
    alu_op_t    alu_op;
    pc_src_t    pc_src;
    logic       trap;
  } ctrl_t;

  // States whose outgoing edge to FETCH completes an instruction.
  function automatic logic retiresFrom(state_t s, logic memReady);
    case (s)
      S_MEMWB, S_ALUWB, S_BEQ, S_ADDIWB, S_JUMP: retiresFrom = 1'b1;
      S_MEMWR:                                   retiresFrom = memReady;
      default:                                   retiresFrom = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller-to-datapath bundle: instruction/status inputs, mux selects,
// write enables and debug/observability outputs.
interface multicycle_control_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic             alu_zero;
  logic             mem_ready;
  logic             pc_en;
  logic             iord;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       pc_src;
  logic             trap;
  logic [3:0]       state;
  logic [CNT_W-1:0] instr_retired;

  modport master (
    input  opcode, alu_zero, mem_ready,
    output pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_src, trap, state,
           instr_retired
  );

  modport slave (
    output opcode, alu_zero, mem_ready,
    input  pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_src, trap, state,
           instr_retired
  );
endinterface

// File: rtl/multicycle_output_decode.sv
// Combinational Moore-style decode of controller state into datapath controls.
// MULTICYCLE_JUMP_EN enables the JUMP state outputs.
module multicycle_output_decode
  import mips_pkg::*;
(
  input  state_t state,
  input  logic   memReady,
  input  logic   aluZero,
  input  logic   reset,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.ir_write  = memReady;
        ctrl.pc_en     = memReady;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_src    = PC_ALUOUT;
        ctrl.pc_en     = aluZero;
      end
      S_ADDIWB: begin
        ctrl.reg_write = 1'b1;
      end
`ifdef MULTICYCLE_JUMP_EN
      S_JUMP: begin
        ctrl.pc_src = PC_JUMP;
        ctrl.pc_en  = 1'b1;
      end
`endif
      S_TRAP: begin
        ctrl.trap = 1'b1;
      end
      default: ;
    endcase

    // Reset masks every side effect immediately, before the state register moves.
    if (!reset) begin
      ctrl.pc_en     = 1'b0;
      ctrl.ir_write  = 1'b0;
      ctrl.mem_read  = 1'b0;
      ctrl.mem_write = 1'b0;
      ctrl.reg_write = 1'b0;
      ctrl.trap      = 1'b0;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS sequencing controller: state register, next-state logic
// and retired-instruction counter. MULTICYCLE_JUMP_EN enables the j opcode.
module multicycle_control
  import mips_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master ctrl
);

  state_t           state;
  state_t           stateNext;
  logic             retire;
  logic [CNT_W-1:0] retiredCnt;
  ctrl_t            dec;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_FETCH;
      retiredCnt <= '0;
    end else begin
      state <= stateNext;
      if (retire) retiredCnt <= retiredCnt + CNT_W'(1);
    end
  end

  always_comb begin
    stateNext = state;
    retire    = retiresFrom(state, ctrl.mem_ready);
    case (state)
      S_FETCH:  if (ctrl.mem_ready) stateNext = S_DECODE;
      S_DECODE: begin
        case (ctrl.opcode)
          OP_RTYPE:     stateNext = S_EXEC;
          OP_LW, OP_SW: stateNext = S_MEMADR;
          OP_BEQ:       stateNext = S_BEQ;
          OP_ADDI:      stateNext = S_ADDIEX;
`ifdef MULTICYCLE_JUMP_EN
          OP_J:         stateNext = S_JUMP;
`endif
          default:      stateNext = S_TRAP;
        endcase
      end
      S_MEMADR: stateNext = (ctrl.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (ctrl.mem_ready) stateNext = S_MEMWB;
      S_MEMWB:  stateNext = S_FETCH;
      S_MEMWR:  if (ctrl.mem_ready) stateNext = S_FETCH;
      S_EXEC:   stateNext = S_ALUWB;
      S_ALUWB:  stateNext = S_FETCH;
      S_BEQ:    stateNext = S_FETCH;
      S_ADDIEX: stateNext = S_ADDIWB;
      S_ADDIWB: stateNext = S_FETCH;
`ifdef MULTICYCLE_JUMP_EN
      S_JUMP:   stateNext = S_FETCH;
`endif
      S_TRAP:   stateNext = S_TRAP;
      // Unused encodings are treated as illegal and halt the machine.
      default:  stateNext = S_TRAP;
    endcase
  end

  multicycle_output_decode uDecode (
    .state    (state),
    .memReady (ctrl.mem_ready),
    .aluZero  (ctrl.alu_zero),
    .reset    (reset),
    .ctrl     (dec)
  );

  assign ctrl.pc_en         = dec.pc_en;
  assign ctrl.iord          = dec.iord;
  assign ctrl.mem_read      = dec.mem_read;
  assign ctrl.mem_write     = dec.mem_write;
  assign ctrl.ir_write      = dec.ir_write;
  assign ctrl.reg_dst       = dec.reg_dst;
  assign ctrl.mem_to_reg    = dec.mem_to_reg;
  assign ctrl.reg_write     = dec.reg_write;
  assign ctrl.alu_src_a     = dec.alu_src_a;
  assign ctrl.alu_src_b     = dec.alu_src_b;
  assign ctrl.alu_op        = dec.alu_op;
  assign ctrl.pc_src        = dec.pc_src;
  assign ctrl.trap          = dec.trap;
  assign ctrl.state         = state;
  assign ctrl.instr_retired = retiredCnt;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencing controller for the MIPS datapath. It replaces the single-cycle control path with a state machine that reuses one ALU and one unified memory port across fetch, decode, execute, memory and write-back steps. Every memory access waits on a ready handshake. The block drives all datapath mux selects and write enables, computes the PC enable from the branch condition, and counts retired instructions.

## Interface
Parameters:
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-low reset.
- `opcode`  in  6  `instruction[31:26]` from the instruction register.
- `alu_zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory has completed the current access this cycle.
- `pc_en`  out  1  PC register load.
- `iord`  out  1  memory address select: 0 = PC, 1 = ALU out register.
- `mem_read`  out  1  memory read request.
- `mem_write`  out  1  memory write request.
- `ir_write`  out  1  instruction register load.
- `reg_dst`  out  1  write-register select: 0 = rt, 1 = rd.
- `mem_to_reg`  out  1  register write data: 0 = ALU out, 1 = memory data register.
- `reg_write`  out  1  register file write enable.
- `alu_src_a`  out  1  ALU A input: 0 = PC, 1 = rs.
- `alu_src_b`  out  2  ALU B input: 00 = rt, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `alu_op`  out  2  ALU operation: 00 = add, 01 = sub, 10 = decode from funct.
- `pc_src`  out  2  PC source: 00 = ALU result, 01 = ALU out register, 10 = jump target.
- `trap`  out  1  an illegal opcode was fetched; the controller is halted.
- `state`  out  4  current state, for debug.
- `instr_retired`  out  `CNT_W`  count of retired instructions.

## Operation
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BEQ 8, ADDIEX 9, ADDIWB 10, JUMP 11, TRAP 12.
- FETCH:
  - Outputs: `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_src`=00, `ir_write`=`pc_en`=`mem_ready`.
  - Stays in FETCH until `mem_ready`, then goes to DECODE.
- DECODE:
  - Outputs: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00. This precomputes the branch target.
  - Next state by opcode: 000000 to EXEC; 100011 (lw) or 101011 (sw) to MEMADR; 000100 to BEQ; 001000 to ADDIEX; 000010 to JUMP; any other opcode to TRAP.
- MEMADR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Next state is MEMRD for lw, MEMWR for sw.
- MEMRD: `mem_read`=1, `iord`=1. Holds until `mem_ready`, then goes to MEMWB.
- MEMWB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1. Retires the instruction; next state FETCH.
- MEMWR: `mem_write`=1, `iord`=1. Holds until `mem_ready`, then retires and goes to FETCH.
- EXEC: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10. Next state ALUWB.
- ALUWB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0. Retires; next state FETCH.
- BEQ:
  - Outputs: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_src`=01, `pc_en`=`alu_zero`.
  - Retires; next state FETCH.
- ADDIEX: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Next state ADDIWB.
- ADDIWB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0. Retires; next state FETCH.
- TRAP:
  - Outputs: `trap`=1; all enables and requests are 0.
  - Absorbing state; only `reset` leaves it.
- Every output not listed for a state is 0.
- `instr_retired` increments by 1 on each retiring transition into FETCH. It wraps from all-ones to 0.

## Timing
- Reset:
  - While `reset`=0 at a clock edge, next state is FETCH and `instr_retired` is 0.
  - While `reset`=0, all enables and requests (`pc_en`, `ir_write`, `mem_read`, `mem_write`, `reg_write`) are forced to 0 combinationally. `trap`=0.
- Reset mid-instruction:
  - The instruction is abandoned and no write occurs after the reset edge.
  - The first cycle after release is FETCH.
- Outputs are decoded combinationally from the state. `mem_ready` gates `ir_write` and `pc_en` in FETCH.
- Request holding: `mem_read` and `mem_write` stay asserted with a stable address select across all wait cycles, including the cycle in which `mem_ready`=1.
- `mem_ready` is ignored outside FETCH, MEMRD and MEMWR.
- Latency with `mem_ready` tied to 1: lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3. Each memory wait cycle adds 1.
- A taken beq loads the PC on the BEQ cycle. A not-taken beq leaves the PC+4 value written in FETCH.

## Configuration
- `MULTICYCLE_JUMP_EN` defined:
  - Opcode 000010 goes to JUMP.
  - JUMP outputs `pc_src`=10 and `pc_en`=1, then retires and goes to FETCH.
- `MULTICYCLE_JUMP_EN` undefined:
  - Opcode 000010 goes to TRAP.
  - The JUMP state encoding is unused; `pc_src`=10 is never driven.

## Structure
- Shared package `mips_pkg` holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J);
  - the 4-bit state enum;
  - the `alu_op`, `alu_src_b` and `pc_src` encodings.
- One sub-module, `multicycle_output_decode`: purely combinational, mapping (state, `mem_ready`, `alu_zero`, `reset`) to the control outputs.
- `multicycle_control` keeps the state register, next-state logic and retire counter.

## Test plan
- R-type, `mem_ready`=1: states run 0, 1, 6, 7, 0. `reg_write`=1 only in cycle 4 with `reg_dst`=1. `instr_retired` goes from 0 to 1.
- lw with `mem_ready` low for 3 cycles in MEMRD: `mem_read`=1 and `iord`=1 are held for 4 cycles, MEMWB follows, total 8 cycles.
- beq with `alu_zero`=1: `pc_en`=1 with `pc_src`=01 in BEQ. With `alu_zero`=0: `pc_en`=0 in BEQ. Both take 3 cycles.
- Opcode 111111: DECODE goes to TRAP; `trap`=1 and the machine stays there for 20 cycles with no enables. `reset`=0 for one edge returns it to FETCH with `trap`=0.
- Reset asserted in MEMWR with `mem_ready`=0: `mem_write` drops to 0 immediately, state is 0 after the edge, and `instr_retired` is 0.
- With `CNT_W`=4, 16 back-to-back addi instructions: `instr_retired` wraps 15 to 0. With the macro defined, j takes 3 cycles; with it undefined, j goes to TRAP.
